pe_array_seq: RTL
=================

Name: pe_array_seq

Overview:
- Sequencer for the 4-row SD4 MAC PE array.
- On `start` it streams K image/weight vector pairs out of the operand buffers, one pair per cycle, into the array.
- Holds `exp_bias` stable for the whole run.
- Emits per-row valid/first/last tags aligned to each row's output. Rows see weights one cycle later per row, plus the PE pipeline latency.
- The downstream psum accumulator uses the tags to zero psum on the first step and commit on the last.

Parameters:
- ROWS, 4, number of PE rows; also the weight skew depth (row r lags row 0 by r cycles).
- PE_LAT, 2, cycles from PE_row operand inputs to that row's `out`.
- AW, 8, operand buffer address width; also width of `k_len`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- k_len  in  AW  number of accumulation steps; sampled with `start`.
- img_base  in  AW  image buffer start address; sampled with `start`.
- wgt_base  in  AW  weight buffer start address; sampled with `start`.
- exp_bias_cfg  in  5  exponent bias for the run; sampled with `start`.
- exp_bias  out  5  latched bias driven to the array.
- img_rd_en  out  1  image buffer read strobe (buffer read latency is 1 cycle).
- img_rd_addr  out  AW  image buffer read address.
- wgt_rd_en  out  1  weight buffer read strobe (1-cycle latency).
- wgt_rd_addr  out  AW  weight buffer read address.
- row_valid  out  ROWS  row r's `out` carries a valid step result this cycle.
- row_first  out  ROWS  that step is step 0 (accumulator uses psum=0).
- row_last  out  ROWS  that step is step K-1 (accumulator commits).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when all rows have drained.

Behaviour:
- Reset values: all outputs 0, including `exp_bias`, addresses, tags, `busy` and `done`. State is IDLE, counters 0, tag pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - `start` with `k_len` != 0 → latch config, go to ISSUE; `busy` rises the next cycle.
  - `start` with `k_len` == 0 → go to FIN; no reads are issued.
- ISSUE:
  - Each cycle, assert `img_rd_en` and `wgt_rd_en` together, with addresses `img_base+k` and `wgt_base+k`, for k = 0..K-1.
  - Addresses wrap modulo 2^AW.
  - After k = K-1 → DRAIN.
- DRAIN: a counter runs ROWS+PE_LAT cycles, then → FIN.
- FIN: `done` = 1 for exactly one cycle, `busy` = 0 in that cycle, then → IDLE.
- Tag timing:
  - Each issue cycle c pushes tag {v=1, first=(k==0), last=(k==K-1)} into a shift pipeline; idle cycles push zeros.
  - Row r sees the tag in cycle c+1+r+PE_LAT (1 cycle buffer read, r cycles weight skew, PE_LAT).
  - Pipeline depth is 1+(ROWS-1)+PE_LAT.
  - With K = 1, `row_first` and `row_last` are both 1 on the same cycle.
- Drain timing: DRAIN is sized so that `done` fires exactly one cycle after `row_valid[ROWS-1]` shows the last tag. With defaults, `done` occurs at c_last+7.
- `exp_bias` changes only when `start` is accepted and is constant throughout ISSUE and DRAIN.
- `start` while `busy` is ignored: no relatch, no effect on the current run.
- abort:
  - In any state, abort → IDLE next cycle.
  - The tag pipeline and counters clear, and read strobes drop.
  - No `done` pulse; `exp_bias` holds.
  - abort wins over a simultaneous `start`.
- Reset mid-run: immediate return to reset values; no `done`.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Tag struct {valid, first, last}.
  - Constants ROWS = 4, PE_LAT = 2, EXP_W = 5, IMG_W = 24, WGT_W = 36, PSUM_W = 16.
- One sub-module, `tag_delay_line`:
  - Parameterized depth shift register of tags, with synchronous clear.
  - Taps at offsets 1+PE_LAT+r, one per row.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0; no reads, tags, or `done`.
- `start`, k_len=3, img_base=0x10, wgt_base=0x20, exp_bias_cfg=15, issue at c=1..3:
  - `img_rd_addr` 0x10,0x11,0x12 and `wgt_rd_addr` 0x20..0x22.
  - `row_valid[0]` in cycles 4–6 and `row_valid[3]` in cycles 7–9.
  - `row_first` on the first of each and `row_last` on the last.
  - `done` at cycle 10; `exp_bias` = 15 throughout.
- k_len=1 → one read; each row's single tag has first=last=1; `done` at c+7.
- k_len=0 → no reads, no tags, `done` pulse 1 cycle after `start`.
- img_base=0xFE, k_len=4 → addresses 0xFE,0xFF,0x00,0x01. A `start` pulsed during the run is ignored and `exp_bias` is unchanged.
- abort during DRAIN of a k_len=5 run → next cycle IDLE, all tags 0, no `done`. A following `start` runs normally.

Source files
------------

// File: rtl/pe_array_seq_pkg.sv
// rtl/pe_array_seq_pkg.sv - shared types and constants for the PE array sequencer
package pe_array_seq_pkg;

    localparam int ROWS   = 4;
    localparam int PE_LAT = 2;
    localparam int EXP_W  = 5;
    localparam int IMG_W  = 24;
    localparam int WGT_W  = 36;
    localparam int PSUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// rtl/tag_delay_line.sv - tag shift register with one tap per PE row
module tag_delay_line
    import pe_array_seq_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int PE_LAT = 2,
    parameter int DEPTH  = ROWS + PE_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  tag_t            tag_in,
    output logic [ROWS-1:0] row_valid,
    output logic [ROWS-1:0] row_first,
    output logic [ROWS-1:0] row_last
);

    // pipe[i] holds the tag pushed i+1 cycles ago
    tag_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    // row r lags by buffer read (1) + weight skew (r) + PE latency
    always_comb begin
        row_valid = '0;
        row_first = '0;
        row_last  = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_valid[r] = pipe[PE_LAT + r].valid;
            row_first[r] = pipe[PE_LAT + r].first;
            row_last[r]  = pipe[PE_LAT + r].last;
        end
    end

endmodule

// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - operand issue and row tag sequencer for the SD4 MAC PE array
module pe_array_seq
    import pe_array_seq_pkg::*;
#(
    parameter int ROWS   = pe_array_seq_pkg::ROWS,
    parameter int PE_LAT = pe_array_seq_pkg::PE_LAT,
    parameter int AW     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   k_len,
    input  logic [AW-1:0]   img_base,
    input  logic [AW-1:0]   wgt_base,
    input  logic [4:0]      exp_bias_cfg,
    output logic [4:0]      exp_bias,
    output logic            img_rd_en,
    output logic [AW-1:0]   img_rd_addr,
    output logic            wgt_rd_en,
    output logic [AW-1:0]   wgt_rd_addr,
    output logic [ROWS-1:0] row_valid,
    output logic [ROWS-1:0] row_first,
    output logic [ROWS-1:0] row_last,
    output logic            busy,
    output logic            done
);

    localparam int DRAIN_CYC = ROWS + PE_LAT;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    seq_state_t    state, state_n;
    logic [AW-1:0] k, k_n;
    logic [DW-1:0] drain, drain_n;
    logic [AW-1:0] k_len_q, img_base_q, wgt_base_q;
    logic [4:0]    exp_bias_q;
    logic          accept, issuing, k_is_last;
    tag_t          tag_in;

    assign accept    = (state == ST_IDLE) && start && !abort && (k_len != '0);
    assign issuing   = (state == ST_ISSUE) && !abort;
    assign k_is_last = (k == k_len_q - AW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            drain      <= '0;
            k_len_q    <= '0;
            img_base_q <= '0;
            wgt_base_q <= '0;
            exp_bias_q <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            drain <= drain_n;
            if (accept) begin
                k_len_q    <= k_len;
                img_base_q <= img_base;
                wgt_base_q <= wgt_base;
                exp_bias_q <= exp_bias_cfg;
            end
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        drain_n = drain;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    k_n     = '0;
                    state_n = (k_len != '0) ? ST_ISSUE : ST_FIN;
                end
            end
            ST_ISSUE: begin
                k_n = k + AW'(1);
                if (k_is_last) begin
                    state_n = ST_DRAIN;
                    drain_n = '0;
                end
            end
            ST_DRAIN: begin
                drain_n = drain + DW'(1);
                if (drain == DW'(DRAIN_CYC - 1)) state_n = ST_FIN;
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (abort) begin
            state_n = ST_IDLE;
            k_n     = '0;
            drain_n = '0;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issuing;
        tag_in.first = issuing && (k == '0);
        tag_in.last  = issuing && k_is_last;
    end

    assign img_rd_en   = issuing;
    assign wgt_rd_en   = issuing;
    assign img_rd_addr = issuing ? img_base_q + k : '0;
    assign wgt_rd_addr = issuing ? wgt_base_q + k : '0;
    assign exp_bias    = exp_bias_q;
    assign busy        = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done        = (state == ST_FIN) && !abort;

    tag_delay_line #(
        .ROWS   (ROWS),
        .PE_LAT (PE_LAT),
        .DEPTH  (ROWS + PE_LAT)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .tag_in    (tag_in),
        .row_valid (row_valid),
        .row_first (row_first),
        .row_last  (row_last)
    );

endmodule
